fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 5-stage RISC-V pipeline, including the IF/ID pipeline register. Holds the PC and fetches instructions over a single-outstanding valid/ack memory interface that tolerates variable latency. Delivers InstrD/PCD/PCPlus4D to the decode stage, where InstrD feeds the register file, control decoder and immediate sign extender. Applies branch/jump redirects from Execute, decode stalls and decode flushes.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched after reset.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low.
- PCSrcE  in  1  redirect request from Execute (taken branch/jump).
- PCTargetE  in  32  redirect target; valid when PCSrcE=1.
- StallD  in  1  decode cannot accept; IF/ID holds its value.
- FlushD  in  1  squash IF/ID contents to a bubble.
- imem_req  out  1  instruction memory request; level, held until acked.
- imem_addr  out  32  request address; stable while imem_req=1.
- imem_ack  in  1  one-cycle response strobe; valid only while imem_req=1.
- imem_rdata  in  32  instruction word; valid with imem_ack.
- InstrD  out  32  IF/ID instruction (bubble = 32'h0000_0013, addi x0,x0,0).
- PCD  out  32  IF/ID PC of InstrD.
- PCPlus4D  out  32  IF/ID PCD+4.
- ValidD  out  1  IF/ID holds a real instruction.

## Operation
- Registers: PCF (next fetch PC), AddrF (address of the outstanding request), a one-entry hold buffer (instruction, PC), state, and the IF/ID register.
- States:
  - REQ: imem_req=1, imem_addr=AddrF=PCF.
  - DRAIN: imem_req=1, imem_addr=AddrF (stale); response is discarded.
  - HOLD: imem_req=0; the fetched instruction waits in the hold buffer.
- Priority each cycle: rst > PCSrcE > FlushD > StallD.
- REQ, ack, no PCSrcE:
  - StallD=0: IF/ID <= {rdata, AddrF, AddrF+4, valid}; PCF, AddrF <= AddrF+4; stay in REQ.
  - StallD=1: capture into the hold buffer; PCF <= AddrF+4; go to HOLD.
- REQ, no ack, StallD=0: IF/ID <= bubble (ValidD=0, InstrD=NOP, PCD/PCPlus4D hold previous values).
- HOLD, StallD=0: IF/ID <= hold buffer; AddrF <= PCF; go to REQ.
- PCSrcE=1: PCF, AddrF <= PCTargetE; IF/ID <= bubble regardless of StallD.
  - In REQ with ack the same cycle: the response is dropped; next state REQ.
  - In REQ without ack: next state DRAIN.
  - In HOLD: the buffer is discarded; next state REQ.
  - In DRAIN: the target is updated; stay in DRAIN.
- DRAIN on ack: drop the data; AddrF <= PCF; go to REQ.
- FlushD=1 (no PCSrcE): IF/ID <= bubble, overriding StallD. It does not touch PCF, the state or the hold buffer.
- All PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0. PCTargetE[1:0] is forced to 2'b00.
- Reset (rst=0 at an edge): PCF=AddrF=RESET_PC, state=REQ, IF/ID=bubble with PCD=PCPlus4D=0 and ValidD=0, hold buffer empty. imem_req=0 while rst=0; it rises in the first cycle after release. Reset mid-request abandons the request; the memory must tolerate the dropped req.

## Timing
- With a zero-wait memory (ack in the same cycle as req): one instruction per cycle. InstrD is valid the cycle after ack.
- N-cycle memory latency: one instruction every N+1 cycles, with a bubble in IF/ID during each wait cycle.
- Redirect penalty with a zero-wait memory: 1 bubble cycle after PCSrcE. With an outstanding slow request, add the remaining drain cycles plus the new fetch latency.
- imem_addr never changes while imem_req=1 and ack has not been seen.
- The hold buffer guarantees that no fetched instruction is lost and no request is duplicated under StallD.

## Test plan
- Reset release, zero-wait memory returning addr-as-data: imem_addr runs 0,4,8,C…; InstrD = 0,4,8… one cycle later; ValidD=1 from the 2nd cycle after release.
- Memory latency 2: ValidD pattern 0,0,1 repeating; no address is repeated or skipped.
- StallD high for 3 cycles while ack arrives at addr 0x10: imem_req low during HOLD; InstrD=0x10 instr is held, then 0x14 follows; each instruction appears exactly once.
- PCSrcE with PCTargetE=0x100 while a 3-cycle request to 0x20 is outstanding: the 0x20 data is never in IF/ID; the next imem_addr after its ack is 0x100; ValidD=0 until 0x100 arrives.
- PCSrcE together with StallD and FlushD in HOLD: the buffer is dropped, IF/ID becomes a bubble, and the next fetch is the target.
- RESET_PC=32'hFFFF_FFFC: the second fetch address is 0; rst pulsed mid-fetch restarts at RESET_PC with ValidD=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register: PC, single-outstanding valid/ack
// fetch with a one-entry hold buffer, redirect draining, stall and flush handling.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallD,
  input  logic        FlushD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pcf;
  logic [31:0] addr_f;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;
  logic [31:0] target;
  logic [31:0] addr_plus4;
  logic [31:0] hold_plus4;
  logic        ack;

  assign target     = PCTargetE & 32'hFFFF_FFFC;
  assign addr_plus4 = addr_f + 32'd4;
  assign hold_plus4 = hold_pc + 32'd4;
  // an ack outside an active request is not a response
  assign ack        = imem_ack && (state != HOLD);
  assign imem_req   = rst && (state != HOLD);
  assign imem_addr  = addr_f;

  // Fetch FSM, PC/address registers, hold buffer and IF/ID register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= REQ;
      pcf        <= RESET_PC;
      addr_f     <= RESET_PC;
      hold_instr <= NOP;
      hold_pc    <= 32'd0;
      InstrD     <= NOP;
      PCD        <= 32'd0;
      PCPlus4D   <= 32'd0;
      ValidD     <= 1'b0;
    end else if (PCSrcE) begin
      pcf    <= target;
      InstrD <= NOP;
      ValidD <= 1'b0;
      // the address may only move once no request is left outstanding
      case (state)
        REQ, DRAIN: begin
          if (ack) begin
            addr_f <= target;
            state  <= REQ;
          end else begin
            state  <= DRAIN;
          end
        end
        HOLD: begin
          addr_f <= target;
          state  <= REQ;
        end
        default: begin
          addr_f <= target;
          state  <= REQ;
        end
      endcase
    end else begin
      case (state)
        REQ: begin
          if (ack) begin
            pcf <= addr_plus4;
            if (StallD) begin
              hold_instr <= imem_rdata;
              hold_pc    <= addr_f;
              state      <= HOLD;
            end else begin
              addr_f <= addr_plus4;
              state  <= REQ;
            end
          end else begin
            state <= REQ;
          end
        end
        DRAIN: begin
          if (ack) begin
            addr_f <= pcf;
            state  <= REQ;
          end else begin
            state <= DRAIN;
          end
        end
        HOLD: begin
          if (!StallD) begin
            addr_f <= pcf;
            state  <= REQ;
          end else begin
            state <= HOLD;
          end
        end
        default: state <= REQ;
      endcase

      if (FlushD) begin
        InstrD <= NOP;
        ValidD <= 1'b0;
      end else if (!StallD) begin
        case (state)
          REQ: begin
            if (ack) begin
              InstrD   <= imem_rdata;
              PCD      <= addr_f;
              PCPlus4D <= addr_plus4;
              ValidD   <= 1'b1;
            end else begin
              InstrD <= NOP;
              ValidD <= 1'b0;
            end
          end
          HOLD: begin
            InstrD   <= hold_instr;
            PCD      <= hold_pc;
            PCPlus4D <= hold_plus4;
            ValidD   <= 1'b1;
          end
          default: begin
            InstrD <= NOP;
            ValidD <= 1'b0;
          end
        endcase
      end else begin
        ValidD <= ValidD;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: an addr-as-data memory with
// programmable latency, plus a second zero-wait instance with RESET_PC at the top of memory.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'd0;
  logic        StallD = 1'b0;
  logic        FlushD = 1'b0;
  logic        imem_req, imem_ack, ValidD;
  logic [31:0] imem_addr, imem_rdata, InstrD, PCD, PCPlus4D;
  logic        imem_req2, imem_ack2, ValidD2;
  logic [31:0] imem_addr2, imem_rdata2, InstrD2, PCD2, PCPlus4D2;

  int lat = 0;
  int wait_cnt = 0;
  int n_checks = 0;
  int n_fail = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .StallD(StallD), .FlushD(FlushD), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_top (
    .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .StallD(StallD), .FlushD(FlushD), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .InstrD(InstrD2), .PCD(PCD2),
    .PCPlus4D(PCPlus4D2), .ValidD(ValidD2)
  );

  always #5 clk = ~clk;

  assign imem_ack    = imem_req && (wait_cnt >= lat);
  assign imem_rdata  = imem_addr;
  assign imem_ack2   = imem_req2;
  assign imem_rdata2 = imem_addr2;

  // Memory wait counter: counts cycles of the current outstanding request
  always @(posedge clk) begin
    if (!imem_req || imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // leaves the bench 2 time units into the first cycle after reset release
  task automatic do_reset(input int l);
    lat = l; PCSrcE = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCTargetE = 32'd0;
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    lat = 0; rst = 1'b0;
    step(); step(); step();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_checks++; if (ValidD !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ValidD); end
    n_checks++; if (InstrD !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h want %h", InstrD, NOP); end
    n_checks++; if (PCD !== 32'd0 || PCPlus4D !== 32'd0) begin n_fail++; $display("FAIL reset_pcd: got %h/%h want 0/0", PCD, PCPlus4D); end
  endtask

  task automatic test_zero_wait();
    do_reset(0);
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL zw_req_rise: got %b want 1", imem_req); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (imem_addr !== 32'(4 * i)) begin n_fail++; $display("FAIL zw_addr[%0d]: got %h want %h", i, imem_addr, 32'(4 * i)); end
      n_checks++; if (ValidD !== (i > 0)) begin n_fail++; $display("FAIL zw_valid[%0d]: got %b want %b", i, ValidD, (i > 0)); end
      if (i > 0) begin
        n_checks++; if (InstrD !== 32'(4 * (i - 1)) || PCD !== 32'(4 * (i - 1)) || PCPlus4D !== 32'(4 * i)) begin
          n_fail++; $display("FAIL zw_ifid[%0d]: got %h/%h/%h want %h/%h/%h", i, InstrD, PCD, PCPlus4D, 32'(4 * (i - 1)), 32'(4 * (i - 1)), 32'(4 * i)); end
      end
      step();
    end
  endtask

  task automatic test_reset_pc_wrap();
    do_reset(0);
    n_checks++; if (imem_addr2 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr0: got %h want fffffffc", imem_addr2); end
    step();
    n_checks++; if (imem_addr2 !== 32'd0) begin n_fail++; $display("FAIL wrap_addr1: got %h want 0", imem_addr2); end
    n_checks++; if (InstrD2 !== 32'hFFFF_FFFC || PCPlus4D2 !== 32'd0 || ValidD2 !== 1'b1) begin
      n_fail++; $display("FAIL wrap_ifid: got %h/%h/%b want fffffffc/0/1", InstrD2, PCPlus4D2, ValidD2); end
    step();
    n_checks++; if (InstrD2 !== 32'd0 || PCD2 !== 32'd0 || PCPlus4D2 !== 32'd4) begin
      n_fail++; $display("FAIL wrap_next: got %h/%h/%h want 0/0/4", InstrD2, PCD2, PCPlus4D2); end
  endtask

  task automatic test_latency2();
    do_reset(2);
    for (int j = 0; j < 12; j++) begin
      n_checks++; if (imem_addr !== 32'(4 * (j / 3))) begin n_fail++; $display("FAIL lat2_addr[%0d]: got %h want %h", j, imem_addr, 32'(4 * (j / 3))); end
      n_checks++; if (ValidD !== (j > 0 && j % 3 == 0)) begin n_fail++; $display("FAIL lat2_valid[%0d]: got %b want %b", j, ValidD, (j > 0 && j % 3 == 0)); end
      if (j > 0 && j % 3 == 0) begin
        n_checks++; if (InstrD !== 32'(4 * (j / 3 - 1))) begin n_fail++; $display("FAIL lat2_instr[%0d]: got %h want %h", j, InstrD, 32'(4 * (j / 3 - 1))); end
      end
      step();
    end
  endtask

  task automatic test_stall_hold();
    do_reset(0);
    step(); step(); step(); step();
    StallD = 1'b1;
    n_checks++; if (imem_addr !== 32'h10 || imem_ack !== 1'b1) begin n_fail++; $display("FAIL st_ack10: got %h/%b want 10/1", imem_addr, imem_ack); end
    for (int k = 0; k < 3; k++) begin
      step();
      if (k == 2) StallD = 1'b0;
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL st_req_low[%0d]: got %b want 0", k, imem_req); end
      n_checks++; if (InstrD !== 32'hC || ValidD !== 1'b1) begin n_fail++; $display("FAIL st_held[%0d]: got %h/%b want c/1", k, InstrD, ValidD); end
    end
    step();
    n_checks++; if (InstrD !== 32'h10 || PCD !== 32'h10 || PCPlus4D !== 32'h14 || ValidD !== 1'b1) begin
      n_fail++; $display("FAIL st_release: got %h/%h/%h/%b want 10/10/14/1", InstrD, PCD, PCPlus4D, ValidD); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin n_fail++; $display("FAIL st_next_req: got %b/%h want 1/14", imem_req, imem_addr); end
    step();
    n_checks++; if (InstrD !== 32'h14) begin n_fail++; $display("FAIL st_after1: got %h want 14", InstrD); end
    step();
    n_checks++; if (InstrD !== 32'h18) begin n_fail++; $display("FAIL st_after2: got %h want 18", InstrD); end
  endtask

  task automatic test_redirect_drain();
    do_reset(0);
    for (int i = 0; i < 8; i++) step();
    lat = 3;
    #1;
    n_checks++; if (imem_addr !== 32'h20 || InstrD !== 32'h1C) begin n_fail++; $display("FAIL rd_start: got %h/%h want 20/1c", imem_addr, InstrD); end
    step();
    PCSrcE = 1'b1; PCTargetE = 32'h100;
    for (int c = 10; c <= 16; c++) begin
      n_checks++; if (ValidD !== 1'b0 || InstrD === 32'h20) begin n_fail++; $display("FAIL rd_bubble[C%0d]: got %h/%b want nop/0", c, InstrD, ValidD); end
      if (c == 11 || c == 12) begin
        n_checks++; if (imem_addr !== 32'h20 || imem_req !== 1'b1) begin n_fail++; $display("FAIL rd_stale[C%0d]: got %h/%b want 20/1", c, imem_addr, imem_req); end
      end
      if (c == 13) begin
        n_checks++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL rd_target: got %h want 100", imem_addr); end
      end
      step();
      PCSrcE = 1'b0;
    end
    n_checks++; if (InstrD !== 32'h100 || PCD !== 32'h100 || ValidD !== 1'b1) begin
      n_fail++; $display("FAIL rd_arrive: got %h/%h/%b want 100/100/1", InstrD, PCD, ValidD); end
  endtask

  task automatic test_redirect_hold();
    do_reset(0);
    step(); step();
    StallD = 1'b1;
    step();
    PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'h0000_0203;
    #1;
    n_checks++; if (imem_req !== 1'b0 || InstrD !== 32'h4) begin n_fail++; $display("FAIL rh_hold: got %b/%h want 0/4", imem_req, InstrD); end
    step();
    PCSrcE = 1'b0; FlushD = 1'b0; StallD = 1'b0;
    #1;
    n_checks++; if (ValidD !== 1'b0 || InstrD !== NOP || PCD !== 32'h4) begin n_fail++; $display("FAIL rh_bubble: got %b/%h/%h want 0/nop/4", ValidD, InstrD, PCD); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL rh_fetch: got %b/%h want 1/200", imem_req, imem_addr); end
    step();
    n_checks++; if (InstrD !== 32'h200 || ValidD !== 1'b1 || imem_addr !== 32'h204) begin
      n_fail++; $display("FAIL rh_arrive: got %h/%b/%h want 200/1/204", InstrD, ValidD, imem_addr); end
    step();
    n_checks++; if (InstrD !== 32'h204) begin n_fail++; $display("FAIL rh_next: got %h want 204", InstrD); end
  endtask

  task automatic test_reset_midfetch();
    do_reset(0);
    step(); step();
    lat = 3;
    step();
    rst = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b0 || imem_ack !== 1'b0) begin n_fail++; $display("FAIL rm_req_low: got %b/%b want 0/0", imem_req, imem_ack); end
    step();
    rst = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin n_fail++; $display("FAIL rm_restart: got %b/%h want 1/0", imem_req, imem_addr); end
    n_checks++; if (ValidD !== 1'b0 || InstrD !== NOP || PCD !== 32'd0) begin n_fail++; $display("FAIL rm_ifid: got %b/%h/%h want 0/nop/0", ValidD, InstrD, PCD); end
    n_checks++; if (imem_addr2 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL rm_top_restart: got %h want fffffffc", imem_addr2); end
    step(); step(); step(); step();
    n_checks++; if (InstrD !== 32'd0 || ValidD !== 1'b1) begin n_fail++; $display("FAIL rm_first: got %h/%b want 0/1", InstrD, ValidD); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_reset_pc_wrap();
    test_latency2();
    test_stall_hold();
    test_redirect_drain();
    test_redirect_hold();
    test_reset_midfetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
